mvm_result_requant: RTL and testbench

Downstream stage of the serial matrix-vector multiplier (mvm_K_B_*). Captures the K signed 2B-bit results the MVM emits serially after asserting done, then requantizes each one: round, arithmetic shift, optional ReLU, saturate to OUT_W bits. Results are buffered in a small FIFO and re-streamed over a valid/ready interface. The next layer's loader can then consume B-bit activations with back-pressure.

---
 rtl/mvm_pkg.sv | 41 ++++
 rtl/mvm_sync_fifo.sv | 71 +++++++
 rtl/mvm_result_requant.sv | 115 +++++++++++
 tb/tb_mvm_result_requant.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvm_pkg.sv
// Shared widths, saturation bounds, FSM state and result payload for the MVM
// result requantizer, plus the round/shift/relu/saturate function.
package mvm_pkg;

  localparam int unsigned B     = 8;
  localparam int unsigned IN_W  = 2 * B;
  localparam int unsigned OUT_W = 8;
  localparam int unsigned EXT_W = IN_W + 1;

  localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } state_t;

  typedef struct packed {
    logic                    last;
    logic signed [OUT_W-1:0] q;
  } res_t;

  localparam int unsigned RES_W = $bits(res_t);

  // Round half up, arithmetic shift, optional ReLU, saturate; one extra bit
  // of headroom keeps the rounding add from wrapping.
  function automatic logic [OUT_W-1:0] requant(input logic [IN_W-1:0] s,
                                               input int unsigned     shift,
                                               input logic            relu);
    logic signed [EXT_W-1:0] r;
    logic signed [EXT_W-1:0] q;
    r = {s[IN_W-1], s};
    if (shift > 0) r = r + (EXT_W'(1) << (shift - 1));
    q = r >>> shift;
    if (relu && (q < 0)) q = '0;
    if (q > SAT_MAX) q = SAT_MAX;
    else if (q < SAT_MIN) q = SAT_MIN;
    return q[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/mvm_sync_fifo.sv
// Synchronous FIFO with occupancy count and a drop strobe for writes that
// find it full; a same-cycle read frees the slot for the write.
module mvm_sync_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 16,
  parameter bit          FWFT  = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data_c,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   drop_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             rd;
  logic             wr;
  logic [CNT_W-1:0] count_nxt;

  always_comb begin
    rd        = rd_en && !empty;
    wr        = wr_en && (!full || rd);
    drop_c    = wr_en && full && !rd;
    count_nxt = count + CNT_W'(wr) - CNT_W'(rd);
  end

  // Storage is cleared on reset so the head reads as zero while empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (rd) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == CNT_W'(DEPTH));
    end
  end

  generate
    if (FWFT) begin : g_fwft
      assign rd_data_c = mem[rd_ptr];
    end else begin : g_reg
      logic [WIDTH-1:0] rdata_q;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) rdata_q <= '0;
        else if (rd) rdata_q <= mem[rd_ptr];
      end
      assign rd_data_c = rdata_q;
    end
  endgenerate

endmodule

// File: rtl/mvm_result_requant.sv
// Captures K serial MVM results after mvm_done, requantizes each one and
// re-streams them from a FWFT FIFO over valid/ready with a last marker.
module mvm_result_requant
  import mvm_pkg::*;
#(
  parameter int unsigned K          = 8,
  parameter int unsigned SHIFT      = 7,
  parameter bit          RELU_EN    = 1'b1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mvm_done,
  input  logic signed [IN_W-1:0]  mvm_data,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    capturing,
  output logic                    overflow,
  output logic                    proto_err,
  input  logic                    clear_err
);

  localparam int unsigned IDX_W = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  logic             sample_c;
  logic             last_c;
  logic             proto_evt_c;
  logic [IN_W-1:0]  s_reg;
  logic             s_valid;
  logic             s_last;
  res_t             wr_res;
  res_t             head;
  logic             drop_c;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             unused_fifo;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mvm_done) state_nxt = CAPTURE;
      CAPTURE: if (idx == IDX_W'(K - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A done pulse inside the window is flagged but never restarts the count.
  always_comb begin
    sample_c    = (state == CAPTURE);
    last_c      = sample_c && (idx == IDX_W'(K - 1));
    proto_evt_c = sample_c && mvm_done;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx       <= '0;
      s_reg     <= '0;
      s_valid   <= 1'b0;
      s_last    <= 1'b0;
      capturing <= 1'b0;
      overflow  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      capturing <= (state_nxt == CAPTURE);
      s_valid   <= sample_c;
      if (sample_c) begin
        s_reg  <= mvm_data;
        s_last <= last_c;
        idx    <= last_c ? '0 : idx + IDX_W'(1);
      end
      overflow  <= drop_c | (overflow & ~clear_err);
      proto_err <= proto_evt_c | (proto_err & ~clear_err);
    end
  end

  always_comb begin
    wr_res.last = s_last;
    wr_res.q    = requant(s_reg, SHIFT, RELU_EN);
  end

  mvm_sync_fifo #(
    .WIDTH (RES_W),
    .DEPTH (FIFO_DEPTH),
    .FWFT  (1'b1)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (s_valid),
    .wr_data   (wr_res),
    .rd_en     (out_ready),
    .rd_data_c (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .drop_c    (drop_c)
  );

  assign out_valid   = ~fifo_empty;
  assign out_data    = head.q;
  assign out_last    = head.last;
  assign unused_fifo = ^{fifo_full, fifo_count};

endmodule

// File: tb/tb_mvm_result_requant.sv
// Bench for mvm_result_requant: a ReLU and a non-ReLU instance share stimulus
// and are compared every cycle against a queue-based reference model.
module tb_mvm_result_requant;

  localparam int K     = 8;
  localparam int SHIFT = 7;
  localparam int DEPTH = 16;
  localparam int OMAX  = 127;
  localparam int OMIN  = -128;

  logic              clk = 1'b0;
  logic              reset;
  logic              mvm_done;
  logic signed [15:0] mvm_data;
  logic              out_ready;
  logic              clear_err;
  logic signed [7:0] out_data, nr_data;
  logic              out_valid, out_last, capturing, overflow, proto_err;
  logic              nr_valid, nr_last, nr_capturing, nr_overflow, nr_proto_err;

  always #5 clk = ~clk;

  mvm_result_requant #(.K(K), .SHIFT(SHIFT), .RELU_EN(1'b1), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .mvm_done(mvm_done), .mvm_data(mvm_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .capturing(capturing), .overflow(overflow),
    .proto_err(proto_err), .clear_err(clear_err));

  mvm_result_requant #(.K(K), .SHIFT(SHIFT), .RELU_EN(1'b0), .FIFO_DEPTH(DEPTH)) dut_nr (
    .clk(clk), .reset(reset), .mvm_done(mvm_done), .mvm_data(mvm_data),
    .out_data(nr_data), .out_valid(nr_valid), .out_ready(out_ready),
    .out_last(nr_last), .capturing(nr_capturing), .overflow(nr_overflow),
    .proto_err(nr_proto_err), .clear_err(clear_err));

  typedef struct {
    bit last;
    int q1;
    int q0;
  } ent_t;

  ent_t mq[$];
  ent_t pend;
  bit   pend_v;
  int   cap_left, cap_idx;
  bit   exp_ovf, exp_pe;
  int   obs_q1[$], obs_q0[$], obs_last[$];
  int   n_pass, n_fail;
  bit   cur_valid;

  function automatic int model_q(input int s, input bit relu);
    int d, r, q;
    d = 1 << SHIFT;
    r = (SHIFT > 0) ? s + d / 2 : s;
    q = (r >= 0) ? r / d : -((-r + d - 1) / d);
    if (relu && q < 0) q = 0;
    if (q > OMAX) q = OMAX;
    if (q < OMIN) q = OMIN;
    return q;
  endfunction

  function automatic logic signed [15:0] rnd16();
    int v;
    case ($urandom_range(0, 2))
      0:       v = int'($urandom_range(0, 65535)) - 32768;
      1:       v = int'($urandom_range(0, 1024)) - 512;
      default: v = ($urandom_range(0, 1) != 0 ? 16384 : -16384) + int'($urandom_range(0, 600)) - 300;
    endcase
    return 16'(v);
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    cur_valid = out_valid;
    chk("out_valid", out_valid, mq.size() > 0);
    chk("nr_valid", nr_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("out_data", out_data, mq[0].q1);
      chk("out_last", out_last, mq[0].last);
      chk("nr_data", nr_data, mq[0].q0);
      chk("nr_last", nr_last, mq[0].last);
    end
    chk("capturing", capturing, cap_left > 0);
    chk("nr_capturing", nr_capturing, cap_left > 0);
    chk("overflow", overflow, exp_ovf);
    chk("nr_overflow", nr_overflow, exp_ovf);
    chk("proto_err", proto_err, exp_pe);
    chk("nr_proto_err", nr_proto_err, exp_pe);
    chk("occupancy", dut.u_fifo.count, mq.size());
  endtask

  // Reference behaviour for one rising edge given this cycle's inputs.
  task automatic model_edge(input bit done, input logic signed [15:0] data, input bit rdy, input bit clr);
    bit ovf_ev = 1'b0;
    bit pe_ev  = 1'b0;
    if (rdy && mq.size() > 0) begin
      obs_q1.push_back(int'(out_data));
      obs_q0.push_back(int'(nr_data));
      obs_last.push_back(int'(out_last));
      void'(mq.pop_front());
    end
    if (pend_v) begin
      if (mq.size() < DEPTH) mq.push_back(pend);
      else ovf_ev = 1'b1;
    end
    pend_v = 1'b0;
    if (cap_left > 0) begin
      pend_v    = 1'b1;
      pend.last = (cap_idx == K - 1);
      pend.q1   = model_q(int'(data), 1'b1);
      pend.q0   = model_q(int'(data), 1'b0);
      cap_idx++;
      cap_left--;
      if (done) pe_ev = 1'b1;
    end else if (done) begin
      cap_left = K;
      cap_idx  = 0;
    end
    exp_ovf = ovf_ev || (exp_ovf && !clr);
    exp_pe  = pe_ev || (exp_pe && !clr);
  endtask

  task automatic step(input bit done, input logic signed [15:0] data, input bit rdy, input bit clr);
    @(negedge clk);
    check_outputs();
    mvm_done  = done;
    mvm_data  = data;
    out_ready = rdy;
    clear_err = clr;
    model_edge(done, data, rdy, clr);
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) step(1'b0, 16'sd0, rdy, 1'b0);
  endtask

  task automatic send_vec(input bit rdy);
    step(1'b1, 16'sd0, rdy, 1'b0);
    for (int j = 0; j < K; j++) step(1'b0, rnd16(), rdy, 1'b0);
  endtask

  task automatic clear_obs();
    obs_q1.delete();
    obs_q0.delete();
    obs_last.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2;
    reset = 1'b0; mvm_done = 1'b0; mvm_data = '0; out_ready = 1'b0; clear_err = 1'b0;
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_last", out_last, 1'b0);
    chk("rst_data", out_data, 0);
    chk("rst_capturing", capturing, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_proto_err", proto_err, 1'b0);
    chk("rst_nr_valid", nr_valid, 1'b0);
    mq.delete();
    pend_v = 1'b0; cap_left = 0; cap_idx = 0; exp_ovf = 1'b0; exp_pe = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic signed [15:0] vb [8];
    int exp1 [8];
    int exp0 [8];
    int lasts;
    bit r;

    n_pass = 0; n_fail = 0;
    reset = 1'b0; mvm_done = 1'b0; mvm_data = '0; out_ready = 1'b0; clear_err = 1'b0;
    pend_v = 1'b0; cap_left = 0; cap_idx = 0; exp_ovf = 1'b0; exp_pe = 1'b0;
    apply_reset();

    // Basic vector with latency check
    vb[0] = 16'sd256;  vb[1] = 16'sd128;   vb[2] = 16'sd63;     vb[3] = 16'sd64;
    vb[4] = -16'sd300; vb[5] = 16'sd32767; vb[6] = 16'sh8000;   vb[7] = 16'sd0;
    exp1 = '{2, 1, 0, 1, 0, 127, 0, 0};
    exp0 = '{2, 1, 0, 1, -2, 127, -128, 0};
    clear_obs();
    step(1'b1, 16'sd0, 1'b1, 1'b0);
    for (int j = 0; j < K; j++) begin
      step(1'b0, vb[j], 1'b1, 1'b0);
      if (j < 4) chk($sformatf("latency_c%0d", j + 1), cur_valid, j >= 2);
    end
    idle(5, 1'b1);
    chk("basic_count", obs_q1.size(), K);
    for (int i = 0; i < K; i++) begin
      chk($sformatf("basic_relu[%0d]", i), obs_q1[i], exp1[i]);
      chk($sformatf("basic_norelu[%0d]", i), obs_q0[i], exp0[i]);
      chk($sformatf("basic_last[%0d]", i), obs_last[i], i == K - 1);
    end

    // Rounding and saturation on the negative side
    vb[0] = -16'sd64;    vb[1] = -16'sd192;   vb[2] = -16'sd193;   vb[3] = 16'sd191;
    vb[4] = 16'sd192;    vb[5] = -16'sd16384; vb[6] = -16'sd16448; vb[7] = -16'sd16449;
    exp1 = '{0, 0, 0, 1, 2, 0, 0, 0};
    exp0 = '{0, -1, -2, 1, 2, -128, -128, -128};
    clear_obs();
    step(1'b1, 16'sd0, 1'b1, 1'b0);
    for (int j = 0; j < K; j++) step(1'b0, vb[j], 1'b1, 1'b0);
    idle(5, 1'b1);
    chk("round_count", obs_q0.size(), K);
    for (int i = 0; i < K; i++) begin
      chk($sformatf("round_relu[%0d]", i), obs_q1[i], exp1[i]);
      chk($sformatf("round_norelu[%0d]", i), obs_q0[i], exp0[i]);
    end

    // Back-pressure: three vectors into a 16-entry FIFO
    clear_obs();
    for (int v = 0; v < 3; v++) send_vec(1'b0);
    idle(3, 1'b0);
    chk("bp_overflow", overflow, 1'b1);
    chk("bp_occupancy", dut.u_fifo.count, 16);
    idle(24, 1'b1);
    lasts = 0;
    foreach (obs_last[i]) lasts += obs_last[i];
    chk("bp_drained", obs_q1.size(), 16);
    chk("bp_lasts", lasts, 2);
    step(1'b0, 16'sd0, 1'b0, 1'b1);
    idle(1, 1'b0);
    chk("bp_cleared", overflow, 1'b0);

    // Full FIFO with a read in the same cycle as the next write
    clear_obs();
    send_vec(1'b0);
    send_vec(1'b0);
    step(1'b1, 16'sd0, 1'b0, 1'b0);
    step(1'b0, rnd16(), 1'b0, 1'b0);
    for (int j = 1; j < K; j++) begin
      step(1'b0, rnd16(), 1'b1, 1'b0);
      if (j == 2) begin
        chk("fs_occupancy", dut.u_fifo.count, 16);
        chk("fs_overflow", overflow, 1'b0);
      end
    end
    idle(24, 1'b1);
    chk("fs_drained", obs_q1.size(), 24);

    // Second done while capturing
    clear_obs();
    step(1'b1, 16'sd0, 1'b1, 1'b0);
    for (int j = 0; j < K; j++) step(j == 3, rnd16(), 1'b1, 1'b0);
    idle(6, 1'b1);
    chk("pe_count", obs_q1.size(), K);
    chk("pe_flag", proto_err, 1'b1);
    chk("pe_capturing", capturing, 1'b0);
    step(1'b0, 16'sd0, 1'b1, 1'b1);

    // Reset in the middle of a capture
    step(1'b1, 16'sd0, 1'b1, 1'b0);
    for (int j = 0; j <= 4; j++) step(1'b0, rnd16(), 1'b1, 1'b0);
    apply_reset();
    clear_obs();
    send_vec(1'b1);
    idle(6, 1'b1);
    chk("rm_count", obs_q1.size(), K);
    chk("rm_overflow", overflow, 1'b0);
    chk("rm_proto_err", proto_err, 1'b0);

    // Randomized traffic with random back-pressure
    for (int v = 0; v < 20; v++) begin
      repeat ($urandom_range(0, 3)) step(1'b0, rnd16(), $urandom_range(0, 3) != 0, 1'b0);
      step(1'b1, rnd16(), $urandom_range(0, 3) != 0, 1'b0);
      for (int j = 0; j < K; j++) begin
        r = $urandom_range(0, 3) != 0;
        step($urandom_range(0, 15) == 0, rnd16(), r, $urandom_range(0, 15) == 0);
      end
    end
    idle(40, 1'b1);
    chk("final_empty", out_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule
